regfile_wb_queue: RTL and testbench
===================================

REGFILE_WB_QUEUE -- requirements
Module: regfile_wb_queue

Interface
REQ-001 SHALL have parameter: DEPTH, 4, number of buffered write entries (power of 2, >=2).
REQ-002 SHALL have port: clock  in  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port: ctrl_reset  in  1  reset, synchronous, active-low (0 at rising edge resets).
REQ-004 SHALL have ports: alu_valid in 1, alu_reg in 5, alu_data in 32  ALU writeback request.
REQ-005 SHALL have ports: md_valid in 1, md_reg in 5, md_data in 32  multdiv writeback request.
REQ-006 SHALL have ports: alu_ready out 1, md_ready out 1  request accepted when valid & ready at rising edge.
REQ-007 SHALL have ports: ctrl_writeEnable out 1, ctrl_writeReg out 5, data_writeReg out 32  drive the register file write port.
REQ-008 SHALL have ports: fwd_regA in 5, fwd_hitA out 1, fwd_dataA out 32; fwd_regB, fwd_hitB, fwd_dataB identical  pending-write lookup.
REQ-009 SHALL have port: count out clog2(DEPTH)+1  occupied FIFO entries.

Function
REQ-010 SHALL buffer entries {reg[4:0], data[31:0]} in a circular FIFO of DEPTH entries; read/write pointers wrap modulo DEPTH.
REQ-011 SHALL compute ready combinationally from registered count only (same-edge pop not credited): free = DEPTH - count.
REQ-012 alu_ready SHALL be 1 iff free >= 1.
REQ-013 md_ready SHALL be 1 iff free >= 2 when alu_valid=1 and alu_reg!=0, else iff free >= 1.
REQ-014 Accepted requests with reg==0 SHALL be consumed (ready honoured) but not enqueued.
REQ-015 Both accepted same edge SHALL enqueue ALU entry first, multdiv entry second (multdiv younger).
REQ-016 Each edge with count>0 (before push) SHALL pop head into output registers: ctrl_writeEnable<=1, ctrl_writeReg<=head.reg, data_writeReg<=head.data.
REQ-017 Each edge with count==0 SHALL set ctrl_writeEnable<=0; ctrl_writeReg/data_writeReg hold.
REQ-018 Latency: entry pushed at edge N into empty FIFO SHALL appear on write port after edge N+1; no same-edge push-to-output bypass.
REQ-019 Push and pop on same edge SHALL update count by (pushes - 1); count never exceeds DEPTH nor underflows.
REQ-020 Drain order SHALL be strict FIFO; at most one regfile write per cycle.
REQ-021 fwd_hitA SHALL be 1 iff fwd_regA!=0 and matches a valid FIFO entry or the output stage with ctrl_writeEnable=1; combinational.
REQ-022 fwd_dataA SHALL return data of youngest match (FIFO tail-most > older FIFO > output stage); 0 when no hit. Same for B.
REQ-023 Forwarding SHALL NOT consider this cycle's input requests.

Reset
REQ-024 On edge with ctrl_reset=0: pointers, count <= 0; ctrl_writeEnable <= 0; ctrl_writeReg <= 0; data_writeReg <= 0.
REQ-025 Reset SHALL override simultaneous push/pop; queued entries discarded mid-operation, never written.
REQ-026 During and after reset, alu_ready=md_ready=1 (count 0) and fwd_hitA=fwd_hitB=0.

Verification
REQ-027 Single write: alu_valid=1, alu_reg=5, alu_data=0x1234 at edge N -> count=1 after N; after N+1 writeEnable=1, writeReg=5, data=0x1234, count=0; after N+2 writeEnable=0.
REQ-028 Dual push ordering: alu(3,0xA) and md(3,0xB) same edge -> fwd_regA=3 gives hit=1, data=0xB; write port shows reg 3 0xA then reg 3 0xB on consecutive cycles.
REQ-029 Full: DEPTH=4, count=3, alu_valid=1 reg 7, md_valid=1 reg 8 -> alu_ready=1, md_ready=0; next cycle count=3 (one push, one pop).
REQ-030 r0 discard: alu_valid=1, alu_reg=0, data 0xFFFF -> alu_ready=1, count unchanged, writeEnable stays 0, fwd_regA=0 hit=0.
REQ-031 Wrap-around: stream 10 ALU writes reg 1..10 back-to-back with DEPTH=4 -> write port emits regs 1..10 in order, data intact, count never >4.
REQ-032 Reset mid-drain: count=3, ctrl_reset=0 one edge -> count=0, writeEnable=0, writeReg=0, data=0; queued entries never appear.

Source files
------------

// File: rtl/regfile_wb_queue_if.sv
// rtl/regfile_wb_queue_if.sv - writeback request, regfile write port and forwarding lookup bundle
interface regfile_wb_queue_if #(
    parameter int DEPTH = 4
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             alu_valid;
    logic [4:0]       alu_reg;
    logic [31:0]      alu_data;
    logic             alu_ready;

    logic             md_valid;
    logic [4:0]       md_reg;
    logic [31:0]      md_data;
    logic             md_ready;

    logic             ctrl_writeEnable;
    logic [4:0]       ctrl_writeReg;
    logic [31:0]      data_writeReg;

    logic [4:0]       fwd_regA;
    logic             fwd_hitA;
    logic [31:0]      fwd_dataA;
    logic [4:0]       fwd_regB;
    logic             fwd_hitB;
    logic [31:0]      fwd_dataB;

    logic [CNT_W-1:0] count;

    modport master (
        output alu_valid, alu_reg, alu_data,
        output md_valid, md_reg, md_data,
        output fwd_regA, fwd_regB,
        input  alu_ready, md_ready,
        input  ctrl_writeEnable, ctrl_writeReg, data_writeReg,
        input  fwd_hitA, fwd_dataA, fwd_hitB, fwd_dataB,
        input  count
    );

    modport slave (
        input  alu_valid, alu_reg, alu_data,
        input  md_valid, md_reg, md_data,
        input  fwd_regA, fwd_regB,
        output alu_ready, md_ready,
        output ctrl_writeEnable, ctrl_writeReg, data_writeReg,
        output fwd_hitA, fwd_dataA, fwd_hitB, fwd_dataB,
        output count
    );
endinterface

// File: rtl/regfile_wb_queue.sv
// rtl/regfile_wb_queue.sv - two-source register writeback FIFO with single-port drain and forwarding
module regfile_wb_queue #(
    parameter int DEPTH = 4
) (
    input logic               clock,
    input logic               ctrl_reset,
    regfile_wb_queue_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] wr_idx;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] free;

    logic [4:0]       mem_reg_q  [DEPTH];
    logic [4:0]       mem_reg_d  [DEPTH];
    logic [31:0]      mem_data_q [DEPTH];
    logic [31:0]      mem_data_d [DEPTH];

    logic             we_q, we_d;
    logic [4:0]       wreg_q, wreg_d;
    logic [31:0]      wdata_q, wdata_d;

    logic             alu_ready, md_ready;
    logic             alu_push, md_push, pop;

    logic [PTR_W-1:0] fwd_idx;
    logic             hit_a, hit_b;
    logic [31:0]      data_a, data_b;

    // Ready looks only at the registered count; a pop on the same edge is not credited.
    always_comb begin
        free      = CNT_W'(DEPTH) - count_q;
        alu_ready = (free != '0);
        if (bus.alu_valid && (bus.alu_reg != 5'd0)) begin
            md_ready = (free >= CNT_W'(2));
        end else begin
            md_ready = (free != '0);
        end
    end

    always_comb begin
        mem_reg_d  = mem_reg_q;
        mem_data_d = mem_data_q;
        rd_ptr_d   = rd_ptr_q;
        we_d       = 1'b0;
        wreg_d     = wreg_q;
        wdata_d    = wdata_q;
        wr_idx     = wr_ptr_q;

        alu_push = bus.alu_valid && alu_ready && (bus.alu_reg != 5'd0);
        md_push  = bus.md_valid  && md_ready  && (bus.md_reg  != 5'd0);
        pop      = (count_q != '0);

        if (pop) begin
            we_d     = 1'b1;
            wreg_d   = mem_reg_q[rd_ptr_q];
            wdata_d  = mem_data_q[rd_ptr_q];
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        // ALU entry lands first so the multdiv entry is the younger of a same-edge pair.
        if (alu_push) begin
            mem_reg_d[wr_idx]  = bus.alu_reg;
            mem_data_d[wr_idx] = bus.alu_data;
            wr_idx             = wr_idx + PTR_W'(1);
        end
        if (md_push) begin
            mem_reg_d[wr_idx]  = bus.md_reg;
            mem_data_d[wr_idx] = bus.md_data;
            wr_idx             = wr_idx + PTR_W'(1);
        end

        wr_ptr_d = wr_idx;
        count_d  = count_q + CNT_W'(alu_push) + CNT_W'(md_push) - CNT_W'(pop);
    end

    // Scan oldest to youngest so the last match wins; the output stage is the oldest of all.
    always_comb begin
        fwd_idx = '0;
        hit_a   = we_q && (wreg_q == bus.fwd_regA);
        data_a  = hit_a ? wdata_q : 32'd0;
        hit_b   = we_q && (wreg_q == bus.fwd_regB);
        data_b  = hit_b ? wdata_q : 32'd0;
        for (int i = 0; i < DEPTH; i++) begin
            fwd_idx = rd_ptr_q + PTR_W'(i);
            if (CNT_W'(i) < count_q) begin
                if (mem_reg_q[fwd_idx] == bus.fwd_regA) begin
                    hit_a  = 1'b1;
                    data_a = mem_data_q[fwd_idx];
                end
                if (mem_reg_q[fwd_idx] == bus.fwd_regB) begin
                    hit_b  = 1'b1;
                    data_b = mem_data_q[fwd_idx];
                end
            end
        end
        if (bus.fwd_regA == 5'd0) begin
            hit_a  = 1'b0;
            data_a = 32'd0;
        end
        if (bus.fwd_regB == 5'd0) begin
            hit_b  = 1'b0;
            data_b = 32'd0;
        end
    end

    always_ff @(posedge clock) begin
        if (!ctrl_reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            we_q     <= 1'b0;
            wreg_q   <= 5'd0;
            wdata_q  <= 32'd0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            we_q     <= we_d;
            wreg_q   <= wreg_d;
            wdata_q  <= wdata_d;
        end
    end

    // Storage needs no reset: nothing is read outside the occupied window.
    always_ff @(posedge clock) begin
        mem_reg_q  <= mem_reg_d;
        mem_data_q <= mem_data_d;
    end

    assign bus.alu_ready        = alu_ready;
    assign bus.md_ready         = md_ready;
    assign bus.ctrl_writeEnable = we_q;
    assign bus.ctrl_writeReg    = wreg_q;
    assign bus.data_writeReg    = wdata_q;
    assign bus.fwd_hitA         = hit_a;
    assign bus.fwd_dataA        = data_a;
    assign bus.fwd_hitB         = hit_b;
    assign bus.fwd_dataB        = data_b;
    assign bus.count            = count_q;
endmodule

// File: tb/tb_regfile_wb_queue.sv
// tb/tb_regfile_wb_queue.sv - vector table, directed corner sequences and randomized model comparison
module tb_regfile_wb_queue;
    localparam int DEPTH = 4;

    logic clock = 1'b0;
    logic ctrl_reset;
    always #5 clock = ~clock;

    regfile_wb_queue_if #(.DEPTH(DEPTH)) bus ();

    regfile_wb_queue #(.DEPTH(DEPTH)) dut (
        .clock      (clock),
        .ctrl_reset (ctrl_reset),
        .bus        (bus)
    );

    typedef struct packed {
        logic [4:0]  r;
        logic [31:0] d;
    } ent_t;

    ent_t        mq [$];
    ent_t        wp_log [$];
    logic        m_we;
    logic [4:0]  m_reg;
    logic [31:0] m_data;

    int n_total = 0;
    int n_pass  = 0;

    logic        s_ar, s_mr, s_hit;
    logic [31:0] s_fd;
    int          max_cnt;

    typedef struct {
        logic        av;
        logic [4:0]  areg;
        logic [31:0] adata;
        logic        mv;
        logic [4:0]  mreg;
        logic [31:0] mdata;
        logic [4:0]  fa;
        logic        e_ar;
        logic        e_mr;
        logic        e_hit;
        logic [31:0] e_fd;
        int          e_cnt;
        logic        e_we;
        logic [4:0]  e_wreg;
        logic [31:0] e_wd;
    } vec_t;

    localparam int NV = 17;
    vec_t vt [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [32:0] m_fwd(input logic [4:0] r);
        if (r == 5'd0) return 33'd0;
        for (int i = mq.size() - 1; i >= 0; i--) begin
            if (mq[i].r == r) return {1'b1, mq[i].d};
        end
        if (m_we && (m_reg == r)) return {1'b1, m_data};
        return 33'd0;
    endfunction

    task automatic set_in(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                          input logic mv, input logic [4:0] mr, input logic [31:0] md,
                          input logic [4:0] fa, input logic [4:0] fb);
        bus.alu_valid = av;
        bus.alu_reg   = ar;
        bus.alu_data  = ad;
        bus.md_valid  = mv;
        bus.md_reg    = mr;
        bus.md_data   = md;
        bus.fwd_regA  = fa;
        bus.fwd_regB  = fb;
    endtask

    // One clock: combinational checks at the falling edge, model step at the rising edge, state checks 1ns later.
    task automatic cycle();
        int          free;
        logic        ar, mr;
        logic [32:0] fa, fb;
        ent_t        e;
        @(negedge clock);
        free = DEPTH - mq.size();
        ar   = (free >= 1);
        mr   = (bus.alu_valid && bus.alu_reg != 5'd0) ? (free >= 2) : (free >= 1);
        fa   = m_fwd(bus.fwd_regA);
        fb   = m_fwd(bus.fwd_regB);
        s_ar = bus.alu_ready;
        s_mr = bus.md_ready;
        s_hit = bus.fwd_hitA;
        s_fd = bus.fwd_dataA;
        chk("alu_ready", 32'(bus.alu_ready), 32'(ar));
        chk("md_ready",  32'(bus.md_ready),  32'(mr));
        chk("fwd_hitA",  32'(bus.fwd_hitA),  32'(fa[32]));
        chk("fwd_dataA", bus.fwd_dataA,      fa[31:0]);
        chk("fwd_hitB",  32'(bus.fwd_hitB),  32'(fb[32]));
        chk("fwd_dataB", bus.fwd_dataB,      fb[31:0]);
        @(posedge clock);
        if (!ctrl_reset) begin
            mq.delete();
            m_we   = 1'b0;
            m_reg  = 5'd0;
            m_data = 32'd0;
        end else begin
            if (mq.size() > 0) begin
                e      = mq.pop_front();
                m_we   = 1'b1;
                m_reg  = e.r;
                m_data = e.d;
            end else begin
                m_we = 1'b0;
            end
            if (bus.alu_valid && ar && bus.alu_reg != 5'd0) mq.push_back({bus.alu_reg, bus.alu_data});
            if (bus.md_valid && mr && bus.md_reg != 5'd0) mq.push_back({bus.md_reg, bus.md_data});
        end
        if (mq.size() > max_cnt) max_cnt = mq.size();
        #1;
        chk("count",        32'(bus.count),            32'(mq.size()));
        chk("writeEnable",  32'(bus.ctrl_writeEnable), 32'(m_we));
        chk("writeReg",     32'(bus.ctrl_writeReg),    32'(m_reg));
        chk("data_writeReg", bus.data_writeReg,        m_data);
        if (bus.ctrl_writeEnable) wp_log.push_back({bus.ctrl_writeReg, bus.data_writeReg});
    endtask

    initial begin
        //            av areg adata     mv mreg mdata    fa  ar mr hit fd        cnt we wreg wd
        vt[0]  = '{1'b0, 5'd0,  32'h0,    1'b0, 5'd0,  32'h0,   5'd0,  1'b1, 1'b1, 1'b0, 32'h0,    0, 1'b0, 5'd0,  32'h0};
        vt[1]  = '{1'b1, 5'd5,  32'h1234, 1'b0, 5'd0,  32'h0,   5'd5,  1'b1, 1'b1, 1'b0, 32'h0,    1, 1'b0, 5'd0,  32'h0};
        vt[2]  = '{1'b0, 5'd0,  32'h0,    1'b0, 5'd0,  32'h0,   5'd5,  1'b1, 1'b1, 1'b1, 32'h1234, 0, 1'b1, 5'd5,  32'h1234};
        vt[3]  = '{1'b0, 5'd0,  32'h0,    1'b0, 5'd0,  32'h0,   5'd5,  1'b1, 1'b1, 1'b1, 32'h1234, 0, 1'b0, 5'd5,  32'h1234};
        vt[4]  = '{1'b1, 5'd3,  32'hA,    1'b1, 5'd3,  32'hB,   5'd3,  1'b1, 1'b1, 1'b0, 32'h0,    2, 1'b0, 5'd5,  32'h1234};
        vt[5]  = '{1'b0, 5'd0,  32'h0,    1'b0, 5'd0,  32'h0,   5'd3,  1'b1, 1'b1, 1'b1, 32'hB,    1, 1'b1, 5'd3,  32'hA};
        vt[6]  = '{1'b0, 5'd0,  32'h0,    1'b0, 5'd0,  32'h0,   5'd3,  1'b1, 1'b1, 1'b1, 32'hB,    0, 1'b1, 5'd3,  32'hB};
        vt[7]  = '{1'b0, 5'd0,  32'h0,    1'b0, 5'd0,  32'h0,   5'd3,  1'b1, 1'b1, 1'b1, 32'hB,    0, 1'b0, 5'd3,  32'hB};
        vt[8]  = '{1'b1, 5'd0,  32'hFFFF, 1'b0, 5'd0,  32'h0,   5'd0,  1'b1, 1'b1, 1'b0, 32'h0,    0, 1'b0, 5'd3,  32'hB};
        vt[9]  = '{1'b1, 5'd7,  32'h70,   1'b1, 5'd8,  32'h80,  5'd0,  1'b1, 1'b1, 1'b0, 32'h0,    2, 1'b0, 5'd3,  32'hB};
        vt[10] = '{1'b1, 5'd9,  32'h90,   1'b1, 5'd10, 32'hA0,  5'd8,  1'b1, 1'b1, 1'b1, 32'h80,   3, 1'b1, 5'd7,  32'h70};
        vt[11] = '{1'b1, 5'd11, 32'hB0,   1'b1, 5'd12, 32'hC0,  5'd12, 1'b1, 1'b0, 1'b0, 32'h0,    3, 1'b1, 5'd8,  32'h80};
        vt[12] = '{1'b0, 5'd0,  32'h0,    1'b1, 5'd13, 32'hD0,  5'd9,  1'b1, 1'b1, 1'b1, 32'h90,   3, 1'b1, 5'd9,  32'h90};
        vt[13] = '{1'b1, 5'd14, 32'hE0,   1'b0, 5'd0,  32'h0,   5'd10, 1'b1, 1'b0, 1'b1, 32'hA0,   3, 1'b1, 5'd10, 32'hA0};
        vt[14] = '{1'b0, 5'd0,  32'h0,    1'b0, 5'd0,  32'h0,   5'd0,  1'b1, 1'b1, 1'b0, 32'h0,    2, 1'b1, 5'd11, 32'hB0};
        vt[15] = '{1'b1, 5'd15, 32'h150,  1'b1, 5'd16, 32'h160, 5'd14, 1'b1, 1'b1, 1'b1, 32'hE0,   3, 1'b1, 5'd13, 32'hD0};
        vt[16] = '{1'b1, 5'd17, 32'h170,  1'b1, 5'd18, 32'h180, 5'd16, 1'b1, 1'b0, 1'b1, 32'h160,  3, 1'b1, 5'd14, 32'hE0};

        m_we    = 1'b0;
        m_reg   = 5'd0;
        m_data  = 32'd0;
        max_cnt = 0;
        ctrl_reset = 1'b0;
        set_in(1'b1, 5'd9, 32'h99, 1'b1, 5'd4, 32'h44, 5'd9, 5'd4);
        @(posedge clock);
        #1;
        cycle();
        chk("reset alu_ready", 32'(s_ar), 32'd1);
        chk("reset md_ready",  32'(s_mr), 32'd1);
        chk("reset fwd_hitA",  32'(s_hit), 32'd0);
        chk("reset count",     32'(bus.count), 32'd0);
        chk("reset writeReg",  32'(bus.ctrl_writeReg), 32'd0);
        ctrl_reset = 1'b1;

        for (int i = 0; i < NV; i++) begin
            set_in(vt[i].av, vt[i].areg, vt[i].adata, vt[i].mv, vt[i].mreg, vt[i].mdata, vt[i].fa, 5'd3);
            cycle();
            chk($sformatf("vec%0d alu_ready", i), 32'(s_ar), 32'(vt[i].e_ar));
            chk($sformatf("vec%0d md_ready", i),  32'(s_mr), 32'(vt[i].e_mr));
            chk($sformatf("vec%0d fwd_hitA", i),  32'(s_hit), 32'(vt[i].e_hit));
            chk($sformatf("vec%0d fwd_dataA", i), s_fd, vt[i].e_fd);
            chk($sformatf("vec%0d count", i),     32'(bus.count), 32'(vt[i].e_cnt));
            chk($sformatf("vec%0d writeEnable", i), 32'(bus.ctrl_writeEnable), 32'(vt[i].e_we));
            chk($sformatf("vec%0d writeReg", i),  32'(bus.ctrl_writeReg), 32'(vt[i].e_wreg));
            chk($sformatf("vec%0d data", i),      bus.data_writeReg, vt[i].e_wd);
        end

        // Back-to-back stream through a reset queue: pointers must wrap with order and data intact.
        ctrl_reset = 1'b0;
        set_in(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
        cycle();
        ctrl_reset = 1'b1;
        wp_log.delete();
        max_cnt = 0;
        for (int i = 1; i <= 10; i++) begin
            set_in(1'b1, 5'(i), 32'(i * 32'h1111), 1'b0, 5'd0, 32'h0, 5'(i), 5'(i - 1));
            cycle();
        end
        set_in(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
        for (int i = 0; i < 3; i++) cycle();
        chk("wrap writes", 32'(wp_log.size()), 32'd10);
        for (int i = 0; i < 10 && i < wp_log.size(); i++) begin
            chk($sformatf("wrap reg%0d", i + 1),  32'(wp_log[i].r), 32'(i + 1));
            chk($sformatf("wrap data%0d", i + 1), wp_log[i].d, 32'((i + 1) * 32'h1111));
        end
        chk("wrap max count", 32'(max_cnt <= DEPTH), 32'd1);

        // Reset while three entries are queued: none of them may reach the write port.
        wp_log.delete();
        set_in(1'b1, 5'd20, 32'h200, 1'b1, 5'd21, 32'h210, 5'd21, 5'd20);
        cycle();
        set_in(1'b1, 5'd22, 32'h220, 1'b1, 5'd23, 32'h230, 5'd23, 5'd21);
        cycle();
        chk("middrain count before", 32'(bus.count), 32'd3);
        ctrl_reset = 1'b0;
        set_in(1'b1, 5'd24, 32'h240, 1'b0, 5'd0, 32'h0, 5'd22, 5'd23);
        cycle();
        chk("middrain count",  32'(bus.count), 32'd0);
        chk("middrain we",     32'(bus.ctrl_writeEnable), 32'd0);
        chk("middrain reg",    32'(bus.ctrl_writeReg), 32'd0);
        chk("middrain data",   bus.data_writeReg, 32'd0);
        ctrl_reset = 1'b1;
        set_in(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd22, 5'd23);
        cycle();
        chk("postreset fwd_hitA", 32'(s_hit), 32'd0);
        for (int i = 0; i < 4; i++) cycle();
        chk("middrain writes", 32'(wp_log.size()), 32'd1);
        if (wp_log.size() > 0) chk("middrain first reg", 32'(wp_log[0].r), 32'd20);

        for (int n = 0; n < 400; n++) begin
            ctrl_reset = ($urandom_range(0, 49) != 0);
            set_in(($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)), $urandom,
                   ($urandom_range(0, 2) != 0), 5'($urandom_range(0, 7)), $urandom,
                   5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
